dmx_frame_gen: RTL and testbench

DMX_FRAME_GEN -- requirements
Module: dmx_frame_gen

---
 rtl/dmx_pkg.sv | 16 +
 rtl/dmx_frame_gen.sv | 156 +++++++++++++++
 tb/tb_dmx_frame_gen.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmx_pkg.sv
// Shared DMX definitions: frame generator state encoding and slot/address limits.
package dmx_pkg;

    localparam int MAX_CH     = 512;
    localparam int DMX_ADDR_W = 9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_FETCH = 3'd2,
        S_LOAD  = 3'd3,
        S_SEND  = 3'd4,
        S_GAP   = 3'd5
    } dmx_state_e;

endpackage

// File: rtl/dmx_frame_gen.sv
// DMX512 frame sequencer: offers start code then channel bytes from RAM to a
// byte transmitter over an avail/ack handshake, with a programmable inter-frame gap.
//
// state | meaning
// IDLE  | waiting for enable; latches count/gap on frame start
// START | start code offered (break flag set) until ack
// FETCH | rd_en pulse, rd_addr = current slot
// LOAD  | RAM byte captured into data, avail raised
// SEND  | channel byte offered until ack
// GAP   | inter-frame idle; frame_done pulses on entry
module dmx_frame_gen
    import dmx_pkg::dmx_state_e, dmx_pkg::S_IDLE, dmx_pkg::S_START, dmx_pkg::S_FETCH,
           dmx_pkg::S_LOAD, dmx_pkg::S_SEND, dmx_pkg::S_GAP, dmx_pkg::DMX_ADDR_W;
#(
    parameter logic [7:0] START_CODE = 8'h00,
    parameter int         MAX_CH     = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [9:0]            ch_count,
    input  logic [15:0]           gap_cycles,
    output logic                  rd_en,
    output logic [DMX_ADDR_W-1:0] rd_addr,
    input  logic [7:0]            rd_data,
    output logic                  avail,
    output logic [8:0]            data,
    input  logic                  ack,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [9:0] MAX_CH_L = 10'(MAX_CH);

    dmx_state_e            state_q, state_d;
    logic [9:0]            count_q, count_d;
    logic [9:0]            slot_q, slot_d;
    logic [15:0]           gap_cnt_q, gap_cnt_d;
    logic [DMX_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic                  avail_q, avail_d;
    logic [8:0]            data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic [9:0]            slot_inc;
    logic                  took;

    assign slot_inc = slot_q + 10'd1;
    assign took     = avail_q & ack;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        slot_d       = slot_q;
        gap_cnt_d    = gap_cnt_q;
        rd_addr_d    = rd_addr_q;
        avail_d      = avail_q;
        data_d       = data_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        rd_en        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    count_d   = (ch_count > MAX_CH_L) ? MAX_CH_L : ch_count;
                    gap_cnt_d = gap_cycles;
                    slot_d    = 10'd0;
                    rd_addr_d = '0;
                    busy_d    = 1'b1;
                    avail_d   = 1'b1;
                    data_d    = {1'b1, START_CODE};
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (took) begin
                    avail_d = 1'b0;
                    if (count_q == 10'd0) begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = S_GAP;
                    end else begin
                        rd_addr_d = slot_q[DMX_ADDR_W-1:0];
                        state_d   = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                rd_en   = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                data_d  = {1'b0, rd_data};
                avail_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (took) begin
                    avail_d = 1'b0;
                    slot_d  = slot_inc;
                    if (slot_inc < count_q) begin
                        rd_addr_d = slot_inc[DMX_ADDR_W-1:0];
                        state_d   = S_FETCH;
                    end else begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = S_GAP;
                    end
                end
            end
            S_GAP: begin
                // GAP plus the IDLE cycle before the next START make frame_done
                // to next avail exactly gap_cycles clocks (minimum one GAP cycle).
                if (gap_cnt_q <= 16'd2) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            slot_q       <= '0;
            gap_cnt_q    <= '0;
            rd_addr_q    <= '0;
            avail_q      <= 1'b0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            slot_q       <= slot_d;
            gap_cnt_q    <= gap_cnt_d;
            rd_addr_q    <= rd_addr_d;
            avail_q      <= avail_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_addr    = rd_addr_q;
    assign avail      = avail_q;
    assign data       = data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dmx_frame_gen.sv
// Directed bench for dmx_frame_gen: a channel RAM model and a handshake-driving
// transmitter stand-in, with hand-computed expected bytes and timings.
module tb_dmx_frame_gen;

    localparam int LIMIT = 300;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [9:0]  ch_count;
    logic [15:0] gap_cycles;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        avail;
    logic [8:0]  data;
    logic        ack;
    logic        busy;
    logic        frame_done;

    logic [7:0]  mem [512];
    int          rd_cnt;
    int          addr_bad;
    logic [8:0]  last_addr;

    int n_checks;
    int n_errors;

    dmx_frame_gen #(.START_CODE(8'h00), .MAX_CH(512)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .ch_count   (ch_count),
        .gap_cycles (gap_cycles),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .avail      (avail),
        .data       (data),
        .ack        (ack),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: data valid one clock after rd_en; also tracks the address walk.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data   <= 8'h00;
            rd_cnt    <= rd_cnt;
            addr_bad  <= addr_bad;
            last_addr <= 9'h000;
        end else if (rd_en) begin
            rd_data   <= mem[rd_addr];
            rd_cnt    <= rd_cnt + 1;
            last_addr <= rd_addr;
            if (rd_addr != 9'h000 && rd_addr != last_addr + 9'h001)
                addr_bad <= addr_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a byte, hold off dly clocks, ack it; w = clocks waited for avail.
    task automatic serve(input int dly, output logic [8:0] d, output int w);
        w = 0;
        while (!avail && w < LIMIT) begin
            tick();
            w++;
        end
        check("avail_wait", 32'(avail), 32'd1);
        d = data;
        repeat (dly) tick();
        check("data_hold", 32'(data), 32'(d));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("avail_drop", 32'(avail), 32'd0);
    endtask

    task automatic start_frame(input logic hold);
        enable = 1'b1;
        tick();
        enable = hold;
    endtask

    initial begin
        logic [8:0] d;
        int         w;
        int         seen;
        int         bad;
        int         rd0;

        n_checks = 0;
        n_errors = 0;
        rd_cnt   = 0;
        addr_bad = 0;
        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;

        rst_n      = 1'b0;
        enable     = 1'b0;
        ch_count   = 10'd0;
        gap_cycles = 16'd0;
        ack        = 1'b0;
        repeat (3) tick();
        check("rst_avail", 32'(avail), 32'd0);
        check("rst_data", 32'(data), 32'h000);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Three slots, ack 5 clk after avail; enable and ch_count drop mid-frame.
        ch_count   = 10'd3;
        gap_cycles = 16'd5;
        start_frame(1'b0);
        ch_count = 10'd0;
        check("f1_busy", 32'(busy), 32'd1);
        serve(5, d, w);
        check("f1_start", 32'(d), 32'h100);
        serve(5, d, w);
        check("f1_lat0", 32'(w), 32'd2);
        check("f1_slot0", 32'(d), 32'h011);
        serve(5, d, w);
        check("f1_slot1", 32'(d), 32'h022);
        serve(5, d, w);
        check("f1_lat2", 32'(w), 32'd2);
        check("f1_slot2", 32'(d), 32'h033);
        check("f1_done", 32'(frame_done), 32'd1);
        check("f1_busy_off", 32'(busy), 32'd0);
        tick();
        check("f1_done_pulse", 32'(frame_done), 32'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (avail) seen++;
            tick();
        end
        check("f1_halt", 32'(seen), 32'd0);

        // Zero slots: only the start code, frame_done right after its ack.
        ch_count   = 10'd0;
        gap_cycles = 16'd0;
        rd0 = rd_cnt;
        start_frame(1'b0);
        serve(0, d, w);
        check("f0_start", 32'(d), 32'h100);
        check("f0_done", 32'(frame_done), 32'd1);
        repeat (10) tick();
        check("f0_no_rd", 32'(rd_cnt - rd0), 32'd0);

        // Long ack stall, then a spurious ack while avail is low.
        ch_count = 10'd2;
        start_frame(1'b0);
        d   = data;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!avail || data != d) bad++;
            tick();
        end
        check("stall_stable", 32'(bad), 32'd0);
        serve(0, d, w);
        check("stall_start", 32'(d), 32'h100);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        serve(0, d, w);
        check("spur_lat", 32'(w), 32'd1);
        check("spur_slot0", 32'(d), 32'h011);
        serve(0, d, w);
        check("spur_slot1", 32'(d), 32'h022);
        check("spur_done", 32'(frame_done), 32'd1);
        repeat (10) tick();

        // Gap of 100 clocks with enable held, then enable dropped mid-frame.
        ch_count   = 10'd1;
        gap_cycles = 16'd100;
        start_frame(1'b1);
        serve(0, d, w);
        serve(0, d, w);
        check("gap_slot0", 32'(d), 32'h011);
        check("gap_done", 32'(frame_done), 32'd1);
        serve(0, d, w);
        check("gap_len", 32'(w), 32'd100);
        check("gap_next_start", 32'(d), 32'h100);
        enable = 1'b0;
        serve(0, d, w);
        check("gap_f2_slot0", 32'(d), 32'h011);
        check("gap_f2_done", 32'(frame_done), 32'd1);
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            if (avail) seen++;
            tick();
        end
        check("gap_halt", 32'(seen), 32'd0);

        // Oversized count clamps to 512 slots, addresses 0..511.
        ch_count   = 10'd600;
        gap_cycles = 16'd0;
        rd0 = rd_cnt;
        bad = 0;
        start_frame(1'b0);
        serve(0, d, w);
        check("big_start", 32'(d), 32'h100);
        for (int i = 0; i < 512; i++) begin
            serve(0, d, w);
            if (d != {1'b0, mem[i]} || w != 2) bad++;
        end
        check("big_bytes", 32'(bad), 32'd0);
        check("big_done", 32'(frame_done), 32'd1);
        check("big_rd_count", 32'(rd_cnt - rd0), 32'd512);
        check("big_last_addr", 32'(last_addr), 32'h1FF);
        check("big_addr_walk", 32'(addr_bad), 32'd0);
        repeat (10) tick();

        // Reset while slot 200 is being offered.
        ch_count = 10'd300;
        start_frame(1'b0);
        serve(0, d, w);
        for (int i = 0; i < 200; i++) serve(0, d, w);
        w = 0;
        while (!avail && w < LIMIT) begin
            tick();
            w++;
        end
        check("rst_mid_slot", 32'(data), 32'({1'b0, mem[200]}));
        rst_n = 1'b0;
        #1;
        check("rstm_avail", 32'(avail), 32'd0);
        check("rstm_data", 32'(data), 32'h000);
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_rd_addr", 32'(rd_addr), 32'd0);
        check("rstm_rd_en", 32'(rd_en), 32'd0);
        check("rstm_frame_done", 32'(frame_done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        ch_count = 10'd1;
        start_frame(1'b0);
        serve(0, d, w);
        check("rstm_restart", 32'(d), 32'h100);
        serve(0, d, w);
        check("rstm_slot0", 32'(d), 32'h011);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
